// File: rtl/periph_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// periph_bus_ctrl_pkg
// Shared definitions for the peripheral bus controller:
//   - bus_state_e      : controller FSM states (IDLE, ACCESS, WAIT, RESP)
//   - DEV_BASE_DEFAULT : default base address of the peripheral window
//   - WINDOW_LSB       : lowest address bit that takes part in the window match
//   - SLOT_LSB/SLOT_W  : position and width of the slot-index field in the address
//   - ERR_CLR_OFFSET   : window offset whose write clears the sticky bus error
//   - DEAD_BEEF        : read data returned when a device access times out
//   - in_window()      : window-match helper
// -----------------------------------------------------------------------------
package periph_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } bus_state_e;

  localparam logic [31:0] DEV_BASE_DEFAULT = 32'h4000_0000;
  localparam int          WINDOW_LSB       = 8;
  localparam int          SLOT_LSB         = 4;
  localparam int          SLOT_W           = 2;
  localparam logic [7:0]  ERR_CLR_OFFSET   = 8'hFC;
  localparam logic [31:0] DEAD_BEEF        = 32'hDEAD_BEEF;

  // Compares only the upper address bits; the low byte selects registers
  // inside the window.
  function automatic logic in_window(input logic [31-WINDOW_LSB:0] addr_hi,
                                     input logic [31-WINDOW_LSB:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/periph_timeout_cnt.sv
// -----------------------------------------------------------------------------
// periph_timeout_cnt
// 8-bit wait counter used while the controller waits for a device.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset (counter -> 0)
//   clear_i  : synchronous clear (takes priority over enable)
//   enable_i : increment by one this cycle
//   expire_o : high while the count equals TIMEOUT
// -----------------------------------------------------------------------------
module periph_timeout_cnt #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == TIMEOUT);

endmodule

// File: rtl/periph_bus_ctrl.sv
// -----------------------------------------------------------------------------
// periph_bus_ctrl
// Bridges CPU MEM-stage loads/stores that fall into the peripheral window onto a
// simple slot-selected device bus, stalling the CPU until the device answers or
// the wait times out.
// Ports:
//   clk, rst            : system clock; asynchronous active-low reset
//   memRead, memWrite   : CPU request strobes (both high = write)
//   memAddr, memDat     : CPU byte address and write data
//   stall               : holds the CPU pipeline during a device access
//   deviceData          : last read data returned to the CPU
//   dev_sel             : one-hot slot strobe, held through ACCESS and WAIT
//   dev_we              : write flag, meaningful while dev_sel is non-zero
//   dev_addr, dev_wdata : request address/data latched at access start
//   dev_ready           : per-slot completion
//   dev_rdata           : per-slot read data, slot i at [32*i +: 32]
//   bus_err             : sticky timeout flag, cleared by a write to BASE+0xFC
// -----------------------------------------------------------------------------
module periph_bus_ctrl
  import periph_bus_ctrl_pkg::*;
#(
  parameter logic [31:0] DEV_BASE = DEV_BASE_DEFAULT,
  parameter int          N_SLOT   = 4,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [31:0]           memAddr,
  input  logic [31:0]           memDat,
  output logic                  stall,
  output logic [31:0]           deviceData,
  output logic [N_SLOT-1:0]     dev_sel,
  output logic                  dev_we,
  output logic [31:0]           dev_addr,
  output logic [31:0]           dev_wdata,
  input  logic [N_SLOT-1:0]     dev_ready,
  input  logic [32*N_SLOT-1:0]  dev_rdata,
  output logic                  bus_err
);

  bus_state_e state_q;
  bus_state_e state_d;

  // Request registers captured when an access is accepted in IDLE.
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        clr_q;    // access is the internal error-clear write

  logic [31:0] data_q;
  logic        err_q;

  logic        req_valid;
  logic        req_is_clr;
  logic        accept;
  logic        wait_done;
  logic        timed_out;
  logic        cnt_clear;
  logic        cnt_en;
  logic        cnt_expire;
  logic        busy;
  logic        sel_ready;

  logic [SLOT_W-1:0] slot_idx;
  logic [N_SLOT-1:0] slot_onehot;
  logic [31:0]       sel_rdata;
  logic [31:0]       rdata_masked [N_SLOT];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign req_valid  = (memRead | memWrite)
                    & in_window(memAddr[31:WINDOW_LSB], DEV_BASE[31:WINDOW_LSB]);
  assign req_is_clr = memWrite & (memAddr[WINDOW_LSB-1:0] == ERR_CLR_OFFSET);

  // ---------------------------------------------------------------------------
  // Slot decode from the registered address; read data is an AND-OR mux so
  // an out-of-range slot simply yields zero and never sees a ready.
  // ---------------------------------------------------------------------------
  assign slot_idx = addr_q[SLOT_LSB +: SLOT_W];

  generate
    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
      assign slot_onehot[gi]  = (slot_idx == SLOT_W'(gi));
      assign rdata_masked[gi] = dev_rdata[gi*32 +: 32] & {32{slot_onehot[gi]}};
    end
  endgenerate

  always_comb begin
    sel_rdata = 32'd0;
    for (int i = 0; i < N_SLOT; i++) begin
      sel_rdata = sel_rdata | rdata_masked[i];
    end
  end

  // Only the selected slot's ready counts.
  assign sel_ready = |(dev_ready & slot_onehot);

  // ---------------------------------------------------------------------------
  // Timeout counter: cleared in ACCESS, advanced on each unanswered WAIT cycle.
  // ---------------------------------------------------------------------------
  periph_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .expire_o (cnt_expire)
  );

  // ---------------------------------------------------------------------------
  // FSM next state and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    accept    = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    wait_done = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Stall must rise in the very cycle the request appears, otherwise
        // the CPU would already have moved past the MEM stage.
        if (req_valid) begin
          stall   = 1'b1;
          accept  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall     = 1'b1;
        cnt_clear = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        // The error-clear write has no device behind it and finishes at once.
        if (clr_q || sel_ready) begin
          wait_done = 1'b1;
          state_d   = ST_RESP;
        end else if (cnt_expire) begin
          wait_done = 1'b1;
          timed_out = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        // A request still present here belongs to the access just finished;
        // it is deliberately not re-accepted.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch, read data and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= memAddr;
      wdata_q <= memDat;
      we_q    <= memWrite;   // read+write together is a write
      clr_q   <= req_is_clr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= 32'd0;
    end else if (wait_done && !we_q) begin
      data_q <= timed_out ? DEAD_BEEF : sel_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (timed_out) begin
      err_q <= 1'b1;
    end else if (wait_done && clr_q) begin
      err_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy       = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
  assign dev_sel    = (busy && !clr_q) ? slot_onehot : '0;
  assign dev_we     = busy & ~clr_q & we_q;
  assign dev_addr   = addr_q;
  assign dev_wdata  = wdata_q;
  assign deviceData = data_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_periph_bus_ctrl
// Directed transactions against periph_bus_ctrl. A transaction-level model
// derives, from the address/strobes and the cycle in which the selected slot
// answers, how long the CPU stays stalled, which slot is strobed and what
// deviceData/bus_err must become. A compare process checks the DUT against
// those expectations on every falling edge; literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_periph_bus_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          TMO  = 255;

  logic         clk;
  logic         rst;
  logic         memRead;
  logic         memWrite;
  logic [31:0]  memAddr;
  logic [31:0]  memDat;
  logic         stall;
  logic [31:0]  deviceData;
  logic [3:0]   dev_sel;
  logic         dev_we;
  logic [31:0]  dev_addr;
  logic [31:0]  dev_wdata;
  logic [3:0]   dev_ready;
  logic [127:0] dev_rdata;
  logic         bus_err;

  logic [31:0] rdata_tbl [4];

  int n_checks = 0;
  int n_err    = 0;
  int txn_no   = 0;

  // Expectations for the compare process
  logic        chk_en;
  logic        exp_stall;
  logic [3:0]  exp_sel;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_data;
  logic        exp_err;

  // Model state carried across transactions
  logic [31:0] m_data;
  logic        m_err;

  // Observations from the last transaction
  int          obs_stall;
  logic [3:0]  obs_sel;
  logic        obs_we;
  logic [31:0] obs_wdata;

  periph_bus_ctrl #(
    .DEV_BASE (BASE),
    .N_SLOT   (4),
    .TIMEOUT  (8'd255)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memAddr    (memAddr),
    .memDat     (memDat),
    .stall      (stall),
    .deviceData (deviceData),
    .dev_sel    (dev_sel),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_ready  (dev_ready),
    .dev_rdata  (dev_rdata),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dev_rdata = {rdata_tbl[3], rdata_tbl[2], rdata_tbl[1], rdata_tbl[0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("dev_sel", 32'(dev_sel), 32'(exp_sel));
      check("deviceData", deviceData, exp_data);
      check("bus_err", 32'(bus_err), 32'(exp_err));
      if (exp_sel != 4'b0000) begin
        check("dev_we", 32'(dev_we), 32'(exp_we));
        check("dev_addr", dev_addr, exp_addr);
        if (exp_we) check("dev_wdata", dev_wdata, exp_wdata);
      end
    end
  end

  // One CPU request. rdy_at = WAIT cycle (1-based) in which the addressed
  // slot raises ready; 0 = never. Non-addressed slots assert ready throughout.
  // Called and returns at posedge+1.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdat,
                         input logic rd, input logic wr, input int rdy_at);
    logic       acc;
    logic       internal;
    logic       timeout;
    logic [3:0] sel;
    logic [31:0] new_data;
    logic       new_err;
    int         slot;
    int         n;
    acc      = (addr[31:8] == BASE[31:8]) && (rd || wr);
    internal = acc && wr && (addr[7:0] == 8'hFC);
    slot     = int'(addr[5:4]);
    sel      = internal ? 4'b0000 : (4'b0001 << slot);
    timeout  = acc && !internal && (rdy_at == 0);
    if (!acc)          n = 0;
    else if (internal) n = 3;
    else if (timeout)  n = 2 + TMO + 1;
    else               n = 2 + rdy_at;
    new_data = m_data;
    if (acc && !wr) new_data = timeout ? 32'hDEAD_BEEF : rdata_tbl[slot];
    new_err = m_err;
    if (timeout)  new_err = 1'b1;
    if (internal) new_err = 1'b0;

    obs_stall = 0;
    obs_sel   = 4'b0000;
    obs_we    = 1'b0;
    obs_wdata = 32'd0;
    exp_addr  = addr;
    exp_wdata = wdat;
    exp_we    = wr;
    chk_en    = 1'b1;
    for (int c = 0; c <= n + 1; c++) begin
      if (c <= n) begin
        memRead = rd; memWrite = wr; memAddr = addr; memDat = wdat;
      end else begin
        memRead = 1'b0; memWrite = 1'b0; memAddr = 32'd0; memDat = 32'd0;
      end
      dev_ready = ~(4'b0001 << slot);
      if (rdy_at > 0 && c == 1 + rdy_at) dev_ready = 4'b1111;
      exp_stall = (c < n);
      exp_sel   = (c >= 1 && c < n) ? sel : 4'b0000;
      exp_data  = (c >= n) ? new_data : m_data;
      exp_err   = (c >= n) ? new_err : m_err;
      @(negedge clk);
      if (stall) obs_stall++;
      obs_sel = obs_sel | dev_sel;
      if (dev_sel != 4'b0000) begin
        obs_we    = obs_we | dev_we;
        obs_wdata = dev_wdata;
      end
      @(posedge clk);
      #1;
    end
    chk_en    = 1'b0;
    dev_ready = 4'b0000;
    m_data    = new_data;
    m_err     = new_err;
    txn_no++;
    $display("txn %0d addr=%h rd=%0b wr=%0b stall_cycles=%0d sel=%b data=%h err=%0b",
             txn_no, addr, rd, wr, obs_stall, obs_sel, deviceData, bus_err);
  endtask

  initial begin
    rdata_tbl[0] = 32'h0BAD_0000;
    rdata_tbl[1] = 32'h0000_1234;
    rdata_tbl[2] = 32'h2222_0002;
    rdata_tbl[3] = 32'h3333_0003;
    rst = 1'b0; memRead = 1'b0; memWrite = 1'b0; memAddr = 32'd0; memDat = 32'd0;
    dev_ready = 4'b0000; chk_en = 1'b0;
    exp_stall = 1'b0; exp_sel = 4'b0000; exp_we = 1'b0; exp_addr = 32'd0;
    exp_wdata = 32'd0; exp_data = 32'd0; exp_err = 1'b0;
    m_data = 32'd0; m_err = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel", 32'(dev_sel), 32'd0);
    check("rst_we", 32'(dev_we), 32'd0);
    check("rst_addr", dev_addr, 32'd0);
    check("rst_wdata", dev_wdata, 32'd0);
    check("rst_data", deviceData, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Read slot1, ready in first WAIT cycle
    run_txn(32'h4000_0010, 32'd0, 1'b1, 1'b0, 1);
    check("r034_stall_cycles", 32'(obs_stall), 32'd3);
    check("r034_sel", 32'(obs_sel), 32'h2);
    check("r034_data", deviceData, 32'h0000_1234);

    // Write slot2, ready after 5 WAIT cycles
    run_txn(32'h4000_0020, 32'h0000_00A5, 1'b0, 1'b1, 5);
    check("r035_stall_cycles", 32'(obs_stall), 32'd7);
    check("r035_we", 32'(obs_we), 32'd1);
    check("r035_wdata", obs_wdata, 32'h0000_00A5);
    check("r035_data_kept", deviceData, 32'h0000_1234);

    // Out-of-window read
    run_txn(32'h1000_0000, 32'd0, 1'b1, 1'b0, 1);
    check("r037_stall_cycles", 32'(obs_stall), 32'd0);
    check("r037_sel", 32'(obs_sel), 32'd0);

    // In-window address with no strobe
    run_txn(32'h4000_0010, 32'd0, 1'b0, 1'b0, 1);
    check("nostrobe_stall_cycles", 32'(obs_stall), 32'd0);

    // Read and write together -> write
    run_txn(32'h4000_0000, 32'h0000_5A5A, 1'b1, 1'b1, 2);
    check("r039_we", 32'(obs_we), 32'd1);
    check("r039_data_kept", deviceData, 32'h0000_1234);

    // Read slot0, ready in third WAIT cycle
    run_txn(32'h4000_0000, 32'd0, 1'b1, 1'b0, 3);
    check("rd0_stall_cycles", 32'(obs_stall), 32'd5);
    check("rd0_data", deviceData, 32'h0BAD_0000);

    // Read slot3, never ready -> timeout
    run_txn(32'h4000_0030, 32'd0, 1'b1, 1'b0, 0);
    check("r036_stall_cycles", 32'(obs_stall), 32'd258);
    check("r036_data", deviceData, 32'hDEAD_BEEF);
    check("r036_err", 32'(bus_err), 32'd1);

    // Normal read leaves the sticky error set
    run_txn(32'h4000_0010, 32'd0, 1'b1, 1'b0, 1);
    check("sticky_err", 32'(bus_err), 32'd1);

    // Error-clear write: internal, no strobe
    run_txn(32'h4000_00FC, 32'd0, 1'b0, 1'b1, 0);
    check("clr_stall_cycles", 32'(obs_stall), 32'd3);
    check("clr_sel", 32'(obs_sel), 32'd0);
    check("clr_err", 32'(bus_err), 32'd0);

    // Read slot3, ready in second WAIT cycle
    run_txn(32'h4000_0030, 32'd0, 1'b1, 1'b0, 2);
    check("rd3_data", deviceData, 32'h3333_0003);

    // Reset during WAIT, then a late ready on slot0
    memRead = 1'b1; memWrite = 1'b0; memAddr = 32'h4000_0000; dev_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #3;
    check("r038_pre_sel", 32'(dev_sel), 32'h1);
    check("r038_pre_stall", 32'(stall), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0; memRead = 1'b0; memAddr = 32'd0;
    #1;
    check("r038_stall", 32'(stall), 32'd0);
    check("r038_sel", 32'(dev_sel), 32'd0);
    check("r038_we", 32'(dev_we), 32'd0);
    check("r038_addr", dev_addr, 32'd0);
    check("r038_wdata", dev_wdata, 32'd0);
    check("r038_data", deviceData, 32'd0);
    check("r038_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      dev_ready = 4'b0001;
      @(negedge clk);
      check("r038_post_stall", 32'(stall), 32'd0);
      check("r038_post_sel", 32'(dev_sel), 32'd0);
      check("r038_post_data", deviceData, 32'd0);
      @(posedge clk); #1;
    end
    dev_ready = 4'b0000;
    m_data = 32'd0; m_err = 1'b0;
    $display("txn %0d reset-abort read addr=40000000 data=%h err=%0b", txn_no + 1, deviceData, bus_err);

    // Controller accepts again after the abort
    run_txn(32'h4000_0010, 32'd0, 1'b1, 1'b0, 1);
    check("after_rst_data", deviceData, 32'h0000_1234);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/periph_bus_ctrl.md
PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
REQ-001 Parameter DEV_BASE, 32'h4000_0000: base of the peripheral window; window = addresses whose [31:8] equal DEV_BASE[31:8].
REQ-002 Parameter N_SLOT, 4: number of device slots; slot index = address[5:4].
REQ-003 Parameter TIMEOUT, 255: maximum cycles to wait for device ready (8-bit counter).
REQ-004 clk  in  1  single system clock (divided CPU clock); all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 memRead  in  1  CPU MEM-stage read request.
REQ-007 memWrite  in  1  CPU MEM-stage write request.
REQ-008 memAddr  in  32  CPU byte address.
REQ-009 memDat  in  32  CPU write data.
REQ-010 stall  out  1  holds the CPU pipeline while a device access is outstanding.
REQ-011 deviceData  out  32  read data returned to the CPU.
REQ-012 dev_sel  out  N_SLOT  one-hot slot strobe, held for the whole access.
REQ-013 dev_we  out  1  1 = write, 0 = read, valid while dev_sel is non-zero.
REQ-014 dev_addr / dev_wdata  out  32 / 32  address and write data latched at access start.
REQ-015 dev_ready  in  N_SLOT  per-slot completion; dev_rdata  in  32*N_SLOT  per-slot read data.
REQ-016 bus_err  out  1  sticky timeout flag; cleared only by reset or a write to DEV_BASE+0xFC.

Function
REQ-017 Accesses outside the window, or with neither memRead nor memWrite asserted, SHALL be ignored (stall=0, dev_sel=0).
REQ-018 FSM states SHALL be IDLE, ACCESS, WAIT, RESP.
REQ-019 IDLE -> ACCESS on an in-window request; stall SHALL assert combinationally in that same cycle.
REQ-020 In ACCESS, dev_sel/dev_we/dev_addr/dev_wdata SHALL be driven from the registered request and the timeout counter SHALL be cleared; ACCESS -> WAIT unconditionally.
REQ-021 In WAIT, the selected dev_ready SHALL move to RESP, capturing dev_rdata of that slot; otherwise the counter SHALL increment.
REQ-022 When the counter reaches TIMEOUT in WAIT, the FSM SHALL move to RESP, set bus_err, and return deviceData = 32'hDEAD_BEEF on a read.
REQ-023 RESP SHALL deassert stall and dev_sel for exactly one cycle, then return to IDLE.
REQ-024 deviceData SHALL hold the last captured value until the next read completes; writes leave it unchanged.
REQ-025 Minimum access latency SHALL be 3 stalled cycles (ready in the first WAIT cycle).
REQ-026 Simultaneous memRead and memWrite SHALL be treated as a write.
REQ-027 A request present in RESP SHALL NOT start a new access before IDLE; no back-to-back merging.
REQ-028 dev_ready of a non-selected slot SHALL be ignored.
REQ-029 A write to DEV_BASE+0xFC SHALL clear bus_err and complete internally in 3 cycles with no dev_sel.

Reset
REQ-030 On rst low: state=IDLE, stall=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0, deviceData=0, bus_err=0, counter=0, asynchronously.
REQ-031 Reset mid-access SHALL abort without waiting for dev_ready; a late dev_ready after reset SHALL be ignored.

Structure
REQ-032 The shared package SHALL hold the state enum, DEV_BASE, the slot-field position, the error-clear offset, and the 32'hDEAD_BEEF constant.
REQ-033 One sub-module, periph_timeout_cnt (clear, enable, expire output), SHALL be instantiated; all other logic stays flat.

Verification
REQ-034 Read 0x4000_0010, slot1 ready on the first WAIT cycle, rdata=0x1234 -> stall high for 3 cycles, dev_sel=4'b0010, deviceData=0x1234.
REQ-035 Write 0x4000_0020 data 0xA5, slot2 ready after 5 cycles -> dev_we=1, dev_wdata=0xA5, stall for 7 cycles, deviceData unchanged.
REQ-036 Read to slot3 with no ready -> after TIMEOUT cycles bus_err=1, deviceData=0xDEADBEEF; a following write to 0x4000_00FC clears bus_err.
REQ-037 Read 0x1000_0000 -> stall=0, dev_sel=0 throughout.
REQ-038 rst low during WAIT, then slot0 ready pulses -> all outputs at reset values, FSM stays IDLE.
REQ-039 memRead and memWrite both high to 0x4000_0000 -> dev_we=1.
